// File: rtl/regfile_bypass_if.sv
// regfile_bypass_if: read, write, forwarding, HI/LO and scoreboard signals of the bypassed register file
interface regfile_bypass_if #(parameter int DW = 32, parameter int AW = 5, parameter int NFWD = 3);
  logic [AW-1:0] raddr1, raddr2;
  logic ren1, ren2;
  logic [DW-1:0] rdata1, rdata2;
  logic we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [NFWD-1:0] fwd_we, fwd_nrdy;
  logic [NFWD*AW-1:0] fwd_waddr;
  logic [NFWD*DW-1:0] fwd_wdata;
  logic hi_we, lo_we;
  logic [DW-1:0] hi_i, lo_i;
  logic [NFWD-1:0] fwd_hi_we, fwd_lo_we;
  logic [NFWD*DW-1:0] fwd_hi, fwd_lo;
  logic [DW-1:0] hi_out, lo_out;
  logic busy_set, hilo_busy_set, hilo_rd;
  logic [AW-1:0] busy_addr;
  logic stall_req;
  modport master (
    output raddr1, raddr2, ren1, ren2, we, waddr, wdata, fwd_we, fwd_waddr, fwd_wdata, fwd_nrdy,
           hi_we, lo_we, hi_i, lo_i, fwd_hi_we, fwd_lo_we, fwd_hi, fwd_lo,
           busy_set, busy_addr, hilo_busy_set, hilo_rd,
    input  rdata1, rdata2, hi_out, lo_out, stall_req
  );
  modport slave (
    input  raddr1, raddr2, ren1, ren2, we, waddr, wdata, fwd_we, fwd_waddr, fwd_wdata, fwd_nrdy,
           hi_we, lo_we, hi_i, lo_i, fwd_hi_we, fwd_lo_we, fwd_hi, fwd_lo,
           busy_set, busy_addr, hilo_busy_set, hilo_rd,
    output rdata1, rdata2, hi_out, lo_out, stall_req
  );
endinterface

// File: rtl/regfile_bypass.sv
// regfile_bypass: GPR/HI/LO file with pipeline forwarding, write bypass and busy-based stall generation
module regfile_bypass #(parameter int DW = 32, parameter int AW = 5, parameter int NFWD = 3) (
  input logic clk,
  input logic resetn,
  regfile_bypass_if.slave bus
);
  localparam int NR = 2 ** AW;
  logic [DW-1:0] gpr [NR];
  logic [NR-1:0] busy;
  logic [DW-1:0] hi, lo, hi_o, lo_o;
  logic hilo_busy;
  logic [AW-1:0] ra [2];
  logic [DW-1:0] rd [2];
  logic [1:0] rn, st;
  assign ra[0] = bus.raddr1;
  assign ra[1] = bus.raddr2;
  assign rn = {bus.ren2, bus.ren1};
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = gpr[ra[p]];
      st[p] = busy[ra[p]];
      if (bus.we && bus.waddr == ra[p]) begin
        rd[p] = bus.wdata;
        st[p] = 1'b0;
      end
      for (int i = NFWD - 1; i >= 0; i--)
        if (bus.fwd_we[i] && bus.fwd_waddr[i*AW +: AW] == ra[p]) begin
          rd[p] = bus.fwd_wdata[i*DW +: DW];
          st[p] = bus.fwd_nrdy[i];
        end
      if (ra[p] == '0) begin
        rd[p] = '0;
        st[p] = 1'b0;
      end
      st[p] = st[p] & rn[p];
    end
  end
  always_comb begin
    hi_o = bus.hi_we ? bus.hi_i : hi;
    lo_o = bus.lo_we ? bus.lo_i : lo;
    for (int i = NFWD - 1; i >= 0; i--) begin
      hi_o = bus.fwd_hi_we[i] ? bus.fwd_hi[i*DW +: DW] : hi_o;
      lo_o = bus.fwd_lo_we[i] ? bus.fwd_lo[i*DW +: DW] : lo_o;
    end
  end
  assign bus.rdata1 = rd[0];
  assign bus.rdata2 = rd[1];
  assign bus.hi_out = hi_o;
  assign bus.lo_out = lo_o;
  assign bus.stall_req = (|st) |
    (bus.hilo_rd & hilo_busy & ~(|bus.fwd_hi_we | |bus.fwd_lo_we | bus.hi_we | bus.lo_we));
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int r = 0; r < NR; r++) gpr[r] <= '0;
      busy <= '0;
      hi <= '0;
      lo <= '0;
      hilo_busy <= 1'b0;
    end else begin
      if (bus.we && bus.waddr != '0) gpr[bus.waddr] <= bus.wdata;
      if (bus.we) busy[bus.waddr] <= 1'b0;
      if (bus.busy_set && bus.busy_addr != '0) busy[bus.busy_addr] <= 1'b1;
      if (bus.hi_we) hi <= bus.hi_i;
      if (bus.lo_we) lo <= bus.lo_i;
      hilo_busy <= bus.hilo_busy_set | (hilo_busy & ~(bus.hi_we | bus.lo_we));
    end
  end
endmodule

// File: doc/regfile_bypass.md
REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 SHALL have parameter DW, default 32: data width of GPRs, HI and LO.
REQ-002 SHALL have parameter AW, default 5: GPR address width; 2**AW registers.
REQ-003 SHALL have parameter NFWD, default 3: number of forwarding sources; index 0 is youngest (EX), NFWD-1 is oldest.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-005 SHALL have port resetn, input, 1: synchronous, active-low reset.
REQ-006 SHALL have ports raddr1/raddr2, input, AW each: read addresses.
REQ-007 SHALL have ports ren1/ren2, input, 1 each: read port actually consumed this cycle.
REQ-008 SHALL have ports rdata1/rdata2, output, DW each: resolved read data.
REQ-009 SHALL have ports we (1), waddr (AW), wdata (DW), all inputs: architectural write port.
REQ-010 SHALL have ports fwd_we (NFWD), fwd_waddr (NFWD*AW), fwd_wdata (NFWD*DW), fwd_nrdy (NFWD), all inputs: per-stage pending GPR result; fwd_nrdy=1 means value not yet produced (load in flight).
REQ-011 SHALL have ports hi_we, lo_we (1 each), hi_i, lo_i (DW each), all inputs: HI/LO write port.
REQ-012 SHALL have ports fwd_hi_we, fwd_lo_we (NFWD each), fwd_hi, fwd_lo (NFWD*DW each), all inputs: per-stage pending HI/LO results.
REQ-013 SHALL have ports hi_out, lo_out, output, DW each: resolved HI/LO.
REQ-014 SHALL have ports busy_set (1), busy_addr (AW), hilo_busy_set (1), all inputs: long-latency issue marks.
REQ-015 SHALL have port hilo_rd, input, 1: HI or LO consumed this cycle.
REQ-016 SHALL have port stall_req, output, 1: ID must hold.

Function
REQ-017 SHALL write wdata into GPR[waddr] on clk edge when we=1 and waddr!=0; GPR[0] reads 0 always.
REQ-018 SHALL resolve each read port by priority: addr 0 -> 0; lowest index i with fwd_we[i] and fwd_waddr[i]==addr -> fwd_wdata[i]; we and waddr==addr -> wdata (same-cycle write bypass); else GPR[addr].
REQ-019 SHALL resolve hi_out by priority: lowest i with fwd_hi_we[i] -> fwd_hi[i]; hi_we -> hi_i; else HI register; lo_out identically with lo signals.
REQ-020 SHALL hold a per-GPR busy bit: set on edge when busy_set=1 and busy_addr!=0; cleared on edge when we=1 and waddr matches; simultaneous set and clear of same address -> set wins.
REQ-021 SHALL hold hilo_busy: set by hilo_busy_set; cleared when hi_we or lo_we; simultaneous -> set wins.
REQ-022 SHALL assert stall_req combinationally when, for any read port with ren=1 and addr!=0: the winning forward source has fwd_nrdy=1, or no forward/write-bypass source matches and busy[addr]=1.
REQ-023 SHALL also assert stall_req when hilo_rd=1, hilo_busy=1 and no fwd_hi_we/fwd_lo_we/hi_we/lo_we bit is set.
REQ-024 SHALL not assert stall_req for ports with ren=0 regardless of address.
REQ-025 SHALL have zero-cycle read latency; written data visible on next cycle from storage.

Reset
REQ-026 SHALL, on clk edge with resetn=0, clear all GPRs, HI, LO, all busy bits and hilo_busy to 0; write/busy inputs ignored that cycle.
REQ-027 SHALL, during and after reset with no forwards active, present rdata1/2=0, hi_out=lo_out=0, stall_req=0.
REQ-028 SHALL abort any pending busy state when reset occurs mid-operation; no stall persists after resetn returns high.

Verification
REQ-029 SHALL pass: write r5=0x1234 -> next cycle raddr1=5 returns 0x1234; write r0=0xFFFF -> raddr1=0 returns 0.
REQ-030 SHALL pass: GPR r3=1, fwd[2]=r3/3, fwd[0]=r3/7, we r3=9 same cycle -> rdata1=7; drop fwd[0] -> 3; drop fwd[2] -> 9.
REQ-031 SHALL pass: fwd_we[0]=1, fwd_nrdy[0]=1, waddr r8, raddr2=8, ren2=1 -> stall_req=1; ren2=0 -> stall_req=0.
REQ-032 SHALL pass: busy_set r10, then raddr1=10, ren1=1 -> stall_req=1 each cycle until we r10=0xAB, that cycle rdata1=0xAB, stall_req=0.
REQ-033 SHALL pass: hilo_busy_set, hilo_rd=1 -> stall until hi_we=1,hi_i=0x55 -> hi_out=0x55, stall_req=0.
REQ-034 SHALL pass: r4=0x99, HI=0x1, busy r6 set, then resetn=0 one cycle -> rdata(4)=0, hi_out=0, raddr 6 read gives stall_req=0.
